wrr_arbiter: RTL and testbench

Weighted round-robin bus arbiter with burst hold. A port that wins keeps ownership for up to its programmed weight in consecutive beats, then ownership passes round-robin to the next requester with no idle bubble. It sits in front of shared interconnect resources (memory port, peripheral bus) where one-beat-per-grant round-robin wastes bandwidth on burst traffic.

---
 rtl/arbiter_pkg.sv | 28 ++
 rtl/rr_pick.sv | 36 +++
 rtl/wrr_arbiter.sv | 136 +++++++++++++
 tb/tb_wrr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int FF1_MAX_W    = 64;
  localparam int FF1_IDX_W    = 6;
  localparam int CREDIT_MAX_W = 16;

  // Lowest set bit index; 0 for an empty vector, so callers test validity themselves.
  function automatic logic [FF1_IDX_W-1:0] ff1(input logic [FF1_MAX_W-1:0] vec);
    logic [FF1_IDX_W-1:0] idx;
    idx = '0;
    for (int i = FF1_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = FF1_IDX_W'(i);
    end
    return idx;
  endfunction

  // A zero weight still earns one beat so a port can never be starved by its own setting.
  function automatic logic [CREDIT_MAX_W-1:0] weight_to_credit(input logic [CREDIT_MAX_W-1:0] w);
    return (w == '0) ? CREDIT_MAX_W'(1) : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr, find first request, rotate the index back.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 valid,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [PTR_W-1:0]     binary
);

  localparam logic [FF1_IDX_W:0] NP = (FF1_IDX_W + 1)'(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] doubled;
  logic [NUM_PORTS-1:0]   rotated;
  logic [FF1_MAX_W-1:0]   padded;
  logic [FF1_IDX_W:0]     offset;
  logic [FF1_IDX_W:0]     sum;

  always_comb begin
    doubled = {request, request} >> ptr;
    rotated = doubled[NUM_PORTS-1:0];
    padded  = FF1_MAX_W'(rotated);
    valid   = |rotated;
    offset  = {1'b0, ff1(padded)};
    sum     = offset + (FF1_IDX_W + 1)'(ptr);
    if (sum >= NP) sum = sum - NP;
    binary  = PTR_W'(sum);
    onehot  = '0;
    if (valid) onehot[binary] = 1'b1;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst hold; define WRR_LOCK_EN to add the per-port lock input.
module wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int WEIGHT_W  = 4,
  parameter int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
`ifdef WRR_LOCK_EN
  input  logic [NUM_PORTS-1:0]          lock,
`endif
  output logic [NUM_PORTS-1:0]          grant,
  output logic [SEL_WIDTH-1:0]          select,
  output logic                          active,
  output logic [WEIGHT_W-1:0]           credit
);

  localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(NUM_PORTS - 1);
  localparam logic [WEIGHT_W-1:0]  ONE       = WEIGHT_W'(1);

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   select_q, select_d;
  logic                   active_q, active_d;
  logic [WEIGHT_W-1:0]    credit_q, credit_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;

  logic [SEL_WIDTH-1:0]   next_ptr;
  logic [SEL_WIDTH-1:0]   search_ptr;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   hold;
  logic                   pick_valid;
  logic [NUM_PORTS-1:0]   pick_onehot;
  logic [SEL_WIDTH-1:0]   pick_bin;
  logic [WEIGHT_W-1:0]    fresh_credit;

  // On release the search starts just past the owner, giving it lowest priority.
  always_comb begin
    next_ptr   = (select_q == LAST_PORT) ? '0 : select_q + 1'b1;
    search_ptr = (state_q == ST_OWN) ? next_ptr : ptr_q;
    owner_req  = request[select_q];
`ifdef WRR_LOCK_EN
    owner_lock = lock[select_q];
`else
    owner_lock = 1'b0;
`endif
    hold         = owner_req && ((credit_q > ONE) || owner_lock);
    fresh_credit = WEIGHT_W'(weight_to_credit(CREDIT_MAX_W'(weight[pick_bin*WEIGHT_W +: WEIGHT_W])));
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (SEL_WIDTH)
  ) u_pick (
    .request (request),
    .ptr     (search_ptr),
    .valid   (pick_valid),
    .onehot  (pick_onehot),
    .binary  (pick_bin)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    active_d = active_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_OWN;
          grant_d  = pick_onehot;
          select_d = pick_bin;
          active_d = 1'b1;
          credit_d = fresh_credit;
        end
      end
      ST_OWN: begin
        if (hold) begin
          credit_d = (credit_q > ONE) ? credit_q - ONE : credit_q;
        end else begin
          ptr_d = next_ptr;
          if (pick_valid) begin
            grant_d  = pick_onehot;
            select_d = pick_bin;
            active_d = 1'b1;
            credit_d = fresh_credit;
          end else begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            select_d = '0;
            active_d = 1'b0;
            credit_d = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        select_d = '0;
        active_d = 1'b0;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      active_q <= 1'b0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      active_q <= active_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign active = active_q;
  assign credit = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: integer-level ownership model plus directed literal checks.
module tb_wrr_arbiter;

  localparam int NUM_PORTS = 6;
  localparam int WEIGHT_W  = 4;
  localparam int SEL_WIDTH = 3;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_PORTS-1:0]          request;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight;
`ifdef WRR_LOCK_EN
  logic [NUM_PORTS-1:0]          lock;
`endif
  logic [NUM_PORTS-1:0]          grant;
  logic [SEL_WIDTH-1:0]          select;
  logic                          active;
  logic [WEIGHT_W-1:0]           credit;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner index (-1 when idle), beats left, and search start.
  int m_owner  = -1;
  int m_credit = 0;
  int m_ptr    = 0;

  wrr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .WEIGHT_W  (WEIGHT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (request),
    .weight  (weight),
`ifdef WRR_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .select  (select),
    .active  (active),
    .credit  (credit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int first_requester(input int start);
    for (int i = 0; i < NUM_PORTS; i++) begin
      int p;
      p = (start + i) % NUM_PORTS;
      if (request[p]) return p;
    end
    return -1;
  endfunction

  function automatic int burst_of(input int p);
    int w;
    w = int'(weight[p*WEIGHT_W +: WEIGHT_W]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit locked(input int p);
`ifdef WRR_LOCK_EN
    return lock[p];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int w;
    if (m_owner < 0) begin
      w = first_requester(m_ptr);
      if (w >= 0) begin
        m_owner  = w;
        m_credit = burst_of(w);
      end
    end else if (request[m_owner] && (m_credit > 1 || locked(m_owner))) begin
      if (m_credit > 1) m_credit--;
    end else begin
      m_ptr = (m_owner + 1) % NUM_PORTS;
      w = first_requester(m_ptr);
      if (w >= 0) begin
        m_owner  = w;
        m_credit = burst_of(w);
      end else begin
        m_owner  = -1;
        m_credit = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  = -1;
      m_credit = 0;
      m_ptr    = 0;
    end else begin
      model_step();
    end
  end

  // Outputs are registered on the rising edge, so compare against the model on the falling edge.
  always @(negedge clk) begin
    checkOutput("model_grant",  32'(grant),  (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    checkOutput("model_select", 32'(select), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    checkOutput("model_active", 32'(active), (m_owner < 0) ? 32'd0 : 32'd1);
    checkOutput("model_credit", 32'(credit), 32'(m_credit));
  end

  task automatic applyStimulus(input logic [NUM_PORTS-1:0] req, input logic [NUM_PORTS*WEIGHT_W-1:0] wts);
    request = req;
    weight  = wts;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    request = '0;
`ifdef WRR_LOCK_EN
    lock    = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [NUM_PORTS-1:0] t2_seq [6] = '{6'b000001, 6'b000001, 6'b000100, 6'b000001, 6'b000001, 6'b000100};

  initial begin
    rst_n   = 1'b0;
    request = '0;
    weight  = '0;
`ifdef WRR_LOCK_EN
    lock    = '0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_grant",  32'(grant),  32'd0);
    checkOutput("reset_select", 32'(select), 32'd0);
    checkOutput("reset_active", 32'(active), 32'd0);
    checkOutput("reset_credit", 32'(credit), 32'd0);
    rst_n = 1'b1;

    // Lone requester with weight 3 gets re-granted back to back.
    $display("[TB] single requester burst");
    applyStimulus(6'b000001, 24'h000003);
    tick(); checkOutput("t1_grant_1", 32'(grant), 32'd1); checkOutput("t1_credit_1", 32'(credit), 32'd3);
    tick(); checkOutput("t1_credit_2", 32'(credit), 32'd2);
    tick(); checkOutput("t1_credit_3", 32'(credit), 32'd1);
    tick(); checkOutput("t1_grant_4", 32'(grant), 32'd1); checkOutput("t1_credit_4", 32'(credit), 32'd3);

    $display("[TB] weighted alternation p0=2 p2=1");
    doReset();
    applyStimulus(6'b000101, 24'h000102);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t2_grant_%0d", i), 32'(grant), 32'(t2_seq[i]));
      checkOutput($sformatf("t2_active_%0d", i), 32'(active), 32'd1);
    end

    $display("[TB] owner drops request early");
    doReset();
    applyStimulus(6'b000010, 24'h002040);
    tick(); checkOutput("t3_grant_p1", 32'(grant), 32'd2); checkOutput("t3_credit_4", 32'(credit), 32'd4);
    tick(); checkOutput("t3_stale_p1", 32'(grant), 32'd2); checkOutput("t3_credit_3", 32'(credit), 32'd3);
    applyStimulus(6'b001000, 24'h002040);
    tick(); checkOutput("t3_grant_p3", 32'(grant), 32'd8); checkOutput("t3_select_p3", 32'(select), 32'd3);
    checkOutput("t3_credit_p3", 32'(credit), 32'd2);
    checkOutput("t3_model_ptr", 32'(m_ptr), 32'd2);
    tick(); checkOutput("t3_credit_p3_1", 32'(credit), 32'd1);
    tick(); checkOutput("t3_regrant_p3", 32'(grant), 32'd8); checkOutput("t3_refresh", 32'(credit), 32'd2);

    $display("[TB] zero weights, all requesting");
    doReset();
    applyStimulus(6'b111111, 24'h000000);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("t4_grant_%0d", i), 32'(grant), 32'd1 << (i % NUM_PORTS));
      checkOutput($sformatf("t4_credit_%0d", i), 32'(credit), 32'd1);
    end

    $display("[TB] reset mid-burst");
    doReset();
    applyStimulus(6'b010100, 24'h000500);
    tick(); checkOutput("t5_grant_p2", 32'(grant), 32'd4); checkOutput("t5_credit_5", 32'(credit), 32'd5);
    tick(); checkOutput("t5_credit_4", 32'(credit), 32'd4);
    #2;
    rst_n   = 1'b0;
    request = 6'b100010;
    #1;
    checkOutput("t5_async_grant",  32'(grant),  32'd0);
    checkOutput("t5_async_select", 32'(select), 32'd0);
    checkOutput("t5_async_active", 32'(active), 32'd0);
    checkOutput("t5_async_credit", 32'(credit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); checkOutput("t5_first_grant", 32'(grant), 32'd2); checkOutput("t5_first_select", 32'(select), 32'd1);

`ifdef WRR_LOCK_EN
    $display("[TB] lock holds owner past credit");
    doReset();
    lock = 6'b000100;
    applyStimulus(6'b000100, 24'h000103);
    tick(); checkOutput("t6_grant_1", 32'(grant), 32'd4); checkOutput("t6_credit_1", 32'(credit), 32'd1);
    request = 6'b000101;
    for (int i = 2; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("t6_hold_%0d", i), 32'(grant), 32'd4);
      checkOutput($sformatf("t6_sat_%0d", i), 32'(credit), 32'd1);
    end
    lock = 6'b000000;
    tick(); checkOutput("t6_grant_p0", 32'(grant), 32'd1); checkOutput("t6_credit_p0", 32'(credit), 32'd3);
`endif

    request = '0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
